// File: rtl/dispatcher_pkg.sv
// Shared types and default widths for the note-event dispatcher.
package dispatcher_pkg;

    typedef enum logic {
        NOTE_OFF = 1'b0,
        NOTE_ON  = 1'b1
    } event_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        COMMIT
    } state_t;

    localparam int DEFAULT_NOTE_WIDTH     = 7;
    localparam int DEFAULT_VELOCITY_WIDTH = 7;

endpackage

// File: rtl/voice_allocator_search.sv
// Combinational search: lowest index i where heystack[i] equals needle, plus a hit flag.
module Search #(
    parameter int WIDTH       = 1,
    parameter int COUNT       = 2,
    parameter int INDEX_WIDTH = $clog2(COUNT)
) (
    input  logic [WIDTH-1:0]            needle,
    input  logic [COUNT-1:0][WIDTH-1:0] heystack,
    output logic                        hit,
    output logic [INDEX_WIDTH-1:0]      index
);

    // NOTE: hit and index get defaults first so no path leaves them unassigned (no latch).
    always_comb begin
        hit   = 1'b0;
        index = '0;
        // Scan from the top down so the lowest matching index is the one that sticks.
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (heystack[i] == needle) begin
                hit   = 1'b1;
                index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Turns NOTE_ON/NOTE_OFF events into voice-table updates with one-cycle trigger/release strobes.
module voice_allocator
    import dispatcher_pkg::*;
#(
    parameter int VOICE_COUNT    = 4,
    parameter int NOTE_WIDTH     = DEFAULT_NOTE_WIDTH,
    parameter int VELOCITY_WIDTH = DEFAULT_VELOCITY_WIDTH
) (
    input  logic                                       clock,
    input  logic                                       reset_l,
    input  logic                                       event_valid,
    output logic                                       event_ready,
    input  event_kind_t                                event_kind,
    input  logic [NOTE_WIDTH-1:0]                      event_note,
    input  logic [VELOCITY_WIDTH-1:0]                  event_velocity,
    output logic [VOICE_COUNT-1:0]                     voice_active,
    output logic [VOICE_COUNT-1:0][NOTE_WIDTH-1:0]     voice_note,
    output logic [VOICE_COUNT-1:0][VELOCITY_WIDTH-1:0] voice_velocity,
    output logic [VOICE_COUNT-1:0]                     voice_trigger,
    output logic [VOICE_COUNT-1:0]                     voice_release
);

    localparam int IDX_W = $clog2(VOICE_COUNT);

    state_t                                     state_q, state_d;
    event_kind_t                                kind_q, kind_d;
    logic [NOTE_WIDTH-1:0]                      note_q, note_d;
    logic [VELOCITY_WIDTH-1:0]                  vel_q, vel_d;
    logic                                       note_hit_q, note_hit_d;
    logic [IDX_W-1:0]                           note_idx_q, note_idx_d;
    logic                                       free_hit_q, free_hit_d;
    logic [IDX_W-1:0]                           free_idx_q, free_idx_d;
    logic [IDX_W-1:0]                           steal_ptr_q, steal_ptr_d;
    logic [VOICE_COUNT-1:0]                     active_q, active_d;
    logic [VOICE_COUNT-1:0][NOTE_WIDTH-1:0]     notes_q, notes_d;
    logic [VOICE_COUNT-1:0][VELOCITY_WIDTH-1:0] vels_q, vels_d;
    logic [VOICE_COUNT-1:0]                     trigger_q, trigger_d;
    logic [VOICE_COUNT-1:0]                     release_q, release_d;

    logic [VOICE_COUNT-1:0][NOTE_WIDTH:0]       note_heystack;
    logic                                       note_hit;
    logic [IDX_W-1:0]                           note_idx;
    logic                                       free_hit;
    logic [IDX_W-1:0]                           free_idx;

    always_comb begin
        for (int i = 0; i < VOICE_COUNT; i++) begin
            note_heystack[i] = {active_q[i], notes_q[i]};
        end
    end

    // Only sounding voices can match because the needle carries active=1.
    Search #(.WIDTH(NOTE_WIDTH + 1), .COUNT(VOICE_COUNT), .INDEX_WIDTH(IDX_W)) u_note_search (
        .needle   ({1'b1, note_q}),
        .heystack (note_heystack),
        .hit      (note_hit),
        .index    (note_idx)
    );

    Search #(.WIDTH(1), .COUNT(VOICE_COUNT), .INDEX_WIDTH(IDX_W)) u_free_search (
        .needle   (1'b0),
        .heystack (active_q),
        .hit      (free_hit),
        .index    (free_idx)
    );

    assign event_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        note_d      = note_q;
        vel_d       = vel_q;
        note_hit_d  = note_hit_q;
        note_idx_d  = note_idx_q;
        free_hit_d  = free_hit_q;
        free_idx_d  = free_idx_q;
        steal_ptr_d = steal_ptr_q;
        active_d    = active_q;
        notes_d     = notes_q;
        vels_d      = vels_q;
        trigger_d   = '0;
        release_d   = '0;

        case (state_q)
            IDLE: begin
                if (event_valid) begin
                    // A zero-velocity NOTE_ON is folded into NOTE_OFF at capture time.
                    kind_d  = (event_kind == NOTE_ON && event_velocity != '0) ? NOTE_ON : NOTE_OFF;
                    note_d  = event_note;
                    vel_d   = event_velocity;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                note_hit_d = note_hit;
                note_idx_d = note_idx;
                free_hit_d = free_hit;
                free_idx_d = free_idx;
                state_d    = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (kind_q == NOTE_ON) begin
                    if (note_hit_q) begin
                        vels_d[note_idx_q]    = vel_q;
                        trigger_d[note_idx_q] = 1'b1;
                    end else if (free_hit_q) begin
                        active_d[free_idx_q]  = 1'b1;
                        notes_d[free_idx_q]   = note_q;
                        vels_d[free_idx_q]    = vel_q;
                        trigger_d[free_idx_q] = 1'b1;
                    end else begin
                        notes_d[steal_ptr_q]   = note_q;
                        vels_d[steal_ptr_q]    = vel_q;
                        trigger_d[steal_ptr_q] = 1'b1;
                        release_d[steal_ptr_q] = 1'b1;
                        // Power-of-two voice count, so natural overflow wraps the pointer.
                        steal_ptr_d            = steal_ptr_q + 1'b1;
                    end
                end else if (note_hit_q) begin
                    active_d[note_idx_q]  = 1'b0;
                    release_d[note_idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the voice table is a small flop array, so it is reset with everything else;
    // downstream generators see a clean zeroed table the instant reset asserts.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            kind_q      <= NOTE_OFF;
            note_q      <= '0;
            vel_q       <= '0;
            note_hit_q  <= 1'b0;
            note_idx_q  <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
            steal_ptr_q <= '0;
            active_q    <= '0;
            notes_q     <= '0;
            vels_q      <= '0;
            trigger_q   <= '0;
            release_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            kind_q      <= kind_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            note_hit_q  <= note_hit_d;
            note_idx_q  <= note_idx_d;
            free_hit_q  <= free_hit_d;
            free_idx_q  <= free_idx_d;
            steal_ptr_q <= steal_ptr_d;
            active_q    <= active_d;
            notes_q     <= notes_d;
            vels_q      <= vels_d;
            trigger_q   <= trigger_d;
            release_q   <= release_d;
        end
    end

    assign voice_active   = active_q;
    assign voice_note     = notes_q;
    assign voice_velocity = vels_q;
    assign voice_trigger  = trigger_q;
    assign voice_release  = release_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with VOICE_COUNT=4: allocation, release, stealing, retrigger, reset.
module tb_voice_allocator;
    import dispatcher_pkg::*;

    logic                 clock;
    logic                 reset_l;
    logic                 event_valid;
    logic                 event_ready;
    event_kind_t          event_kind;
    logic [6:0]           event_note;
    logic [6:0]           event_velocity;
    logic [3:0]           voice_active;
    logic [3:0][6:0]      voice_note;
    logic [3:0][6:0]      voice_velocity;
    logic [3:0]           voice_trigger;
    logic [3:0]           voice_release;

    int tests_run    = 0;
    int tests_failed = 0;

    voice_allocator #(.VOICE_COUNT(4), .NOTE_WIDTH(7), .VELOCITY_WIDTH(7)) dut (
        .clock          (clock),
        .reset_l        (reset_l),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_kind     (event_kind),
        .event_note     (event_note),
        .event_velocity (event_velocity),
        .voice_active   (voice_active),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_trigger  (voice_trigger),
        .voice_release  (voice_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Drives one transfer and returns the strobes seen in the cycle after the commit edge.
    task automatic send_event(input event_kind_t kind, input logic [6:0] note, input logic [6:0] vel,
                              output logic [3:0] trig, output logic [3:0] rel);
        @(negedge clock);
        event_valid = 1'b1; event_kind = kind; event_note = note; event_velocity = vel;
        tests_run++;
        if (event_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ready_before_transfer: got %b expected 1", event_ready);
        end
        @(posedge clock);
        #1 event_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            tests_run++;
            if (event_ready !== 1'b0 || voice_trigger !== 4'b0 || voice_release !== 4'b0) begin
                tests_failed++;
                $display("FAIL busy_cycle%0d: ready=%b trig=%b rel=%b expected ready=0 trig=0000 rel=0000",
                         c, event_ready, voice_trigger, voice_release);
            end
        end
        @(negedge clock);
        trig = voice_trigger; rel = voice_release;
        tests_run++;
        if (event_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ready_after_commit: got %b expected 1", event_ready);
        end
        @(negedge clock);
        tests_run++;
        if (voice_trigger !== 4'b0 || voice_release !== 4'b0) begin
            tests_failed++;
            $display("FAIL strobe_width: trig=%b rel=%b expected 0000/0000", voice_trigger, voice_release);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_l = 1'b0;
        #2 reset_l = 1'b1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; event_valid = 1'b0; event_kind = NOTE_OFF; event_note = '0; event_velocity = '0;
        #1;
        tests_run++;
        if (voice_active !== 4'b0000 || voice_trigger !== 4'b0000 || voice_release !== 4'b0000 ||
            event_ready !== 1'b1 || voice_note !== 28'h0 || voice_velocity !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_state: active=%b trig=%b rel=%b ready=%b notes=%h vels=%h expected 0000/0000/0000/1/0/0",
                     voice_active, voice_trigger, voice_release, event_ready, voice_note, voice_velocity);
        end
        #12 reset_l = 1'b1;
    endtask

    task automatic test_alloc();
        logic [3:0] t, r;
        send_event(NOTE_ON, 7'd60, 7'd100, t, r);
        tests_run++;
        if (t !== 4'b0001 || r !== 4'b0000) begin
            tests_failed++; $display("FAIL alloc_first_strobes: trig=%b rel=%b expected 0001/0000", t, r);
        end
        send_event(NOTE_ON, 7'd64, 7'd80, t, r);
        tests_run++;
        if (t !== 4'b0010 || r !== 4'b0000) begin
            tests_failed++; $display("FAIL alloc_second_strobes: trig=%b rel=%b expected 0010/0000", t, r);
        end
        tests_run++;
        if (voice_active !== 4'b0011 || voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100 ||
            voice_note[1] !== 7'd64 || voice_velocity[1] !== 7'd80) begin
            tests_failed++;
            $display("FAIL alloc_table: active=%b v0=%0d/%0d v1=%0d/%0d expected 0011 v0=60/100 v1=64/80",
                     voice_active, voice_note[0], voice_velocity[0], voice_note[1], voice_velocity[1]);
        end
    endtask

    task automatic test_release();
        logic [3:0] t, r;
        send_event(NOTE_OFF, 7'd60, 7'd0, t, r);
        tests_run++;
        if (t !== 4'b0000 || r !== 4'b0001 || voice_active !== 4'b0010 || voice_note[0] !== 7'd60) begin
            tests_failed++;
            $display("FAIL release_hit: trig=%b rel=%b active=%b note0=%0d expected 0000/0001/0010/60",
                     t, r, voice_active, voice_note[0]);
        end
        send_event(NOTE_OFF, 7'd70, 7'd0, t, r);
        tests_run++;
        if (t !== 4'b0000 || r !== 4'b0000 || voice_active !== 4'b0010 || voice_note[1] !== 7'd64) begin
            tests_failed++;
            $display("FAIL release_miss: trig=%b rel=%b active=%b note1=%0d expected 0000/0000/0010/64",
                     t, r, voice_active, voice_note[1]);
        end
    endtask

    task automatic test_steal();
        logic [3:0] t, r;
        apply_reset();
        send_event(NOTE_ON, 7'd60, 7'd10, t, r);
        send_event(NOTE_ON, 7'd62, 7'd11, t, r);
        send_event(NOTE_ON, 7'd64, 7'd12, t, r);
        send_event(NOTE_ON, 7'd65, 7'd13, t, r);
        tests_run++;
        if (t !== 4'b1000 || voice_active !== 4'b1111) begin
            tests_failed++; $display("FAIL steal_fill: trig=%b active=%b expected 1000/1111", t, voice_active);
        end
        send_event(NOTE_ON, 7'd67, 7'd90, t, r);
        tests_run++;
        if (t !== 4'b0001 || r !== 4'b0001 || voice_note[0] !== 7'd67 || voice_velocity[0] !== 7'd90) begin
            tests_failed++;
            $display("FAIL steal_first: trig=%b rel=%b v0=%0d/%0d expected 0001/0001 v0=67/90",
                     t, r, voice_note[0], voice_velocity[0]);
        end
        send_event(NOTE_ON, 7'd69, 7'd50, t, r);
        tests_run++;
        if (t !== 4'b0010 || r !== 4'b0010 || voice_note[1] !== 7'd69 || voice_active !== 4'b1111) begin
            tests_failed++;
            $display("FAIL steal_second: trig=%b rel=%b note1=%0d active=%b expected 0010/0010/69/1111",
                     t, r, voice_note[1], voice_active);
        end
    endtask

    // Table is 67,69,64,65 with the steal pointer at voice 2.
    task automatic test_back_to_back();
        logic [3:0] t, r;
        send_event(NOTE_OFF, 7'd64, 7'd0, t, r);
        tests_run++;
        if (r !== 4'b0100 || voice_active !== 4'b1011) begin
            tests_failed++; $display("FAIL b2b_off: rel=%b active=%b expected 0100/1011", r, voice_active);
        end
        send_event(NOTE_ON, 7'd71, 7'd40, t, r);
        tests_run++;
        if (t !== 4'b0100 || r !== 4'b0000 || voice_note[2] !== 7'd71) begin
            tests_failed++;
            $display("FAIL b2b_free: trig=%b rel=%b note2=%0d expected 0100/0000/71", t, r, voice_note[2]);
        end
        send_event(NOTE_ON, 7'd72, 7'd41, t, r);
        tests_run++;
        if (t !== 4'b0100 || r !== 4'b0100 || voice_note[2] !== 7'd72) begin
            tests_failed++;
            $display("FAIL b2b_steal_ptr: trig=%b rel=%b note2=%0d expected 0100/0100/72", t, r, voice_note[2]);
        end
        send_event(NOTE_ON, 7'd67, 7'd5, t, r);
        tests_run++;
        if (t !== 4'b0001 || r !== 4'b0000 || voice_velocity[0] !== 7'd5 || voice_note[3] !== 7'd65) begin
            tests_failed++;
            $display("FAIL b2b_hit_when_full: trig=%b rel=%b vel0=%0d note3=%0d expected 0001/0000/5/65",
                     t, r, voice_velocity[0], voice_note[3]);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] t, r;
        apply_reset();
        send_event(NOTE_ON, 7'd60, 7'd30, t, r);
        send_event(NOTE_ON, 7'd62, 7'd31, t, r);
        send_event(NOTE_ON, 7'd62, 7'd20, t, r);
        tests_run++;
        if (t !== 4'b0010 || r !== 4'b0000 || voice_velocity[1] !== 7'd20 || voice_active !== 4'b0011) begin
            tests_failed++;
            $display("FAIL retrigger: trig=%b rel=%b vel1=%0d active=%b expected 0010/0000/20/0011",
                     t, r, voice_velocity[1], voice_active);
        end
        send_event(NOTE_ON, 7'd62, 7'd0, t, r);
        tests_run++;
        if (t !== 4'b0000 || r !== 4'b0010 || voice_active !== 4'b0001) begin
            tests_failed++;
            $display("FAIL vel0_as_off: trig=%b rel=%b active=%b expected 0000/0010/0001", t, r, voice_active);
        end
    endtask

    task automatic test_reset_in_flight();
        logic [3:0] t, r;
        @(negedge clock);
        event_valid = 1'b1; event_kind = NOTE_ON; event_note = 7'd50; event_velocity = 7'd10;
        @(posedge clock);
        #1 event_valid = 1'b0;
        #2 reset_l = 1'b0;
        #1;
        tests_run++;
        if (voice_active !== 4'b0000 || event_ready !== 1'b1 || voice_note !== 28'h0 || voice_velocity !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_async: active=%b ready=%b notes=%h vels=%h expected 0000/1/0/0",
                     voice_active, event_ready, voice_note, voice_velocity);
        end
        event_valid = 1'b1; event_note = 7'd55; event_velocity = 7'd30;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            tests_run++;
            if (event_ready !== 1'b1 || voice_active !== 4'b0000 || voice_trigger !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_hold%0d: ready=%b active=%b trig=%b expected 1/0000/0000",
                         c, event_ready, voice_active, voice_trigger);
            end
        end
        event_valid = 1'b0;
        reset_l = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests_run++;
            if (voice_trigger !== 4'b0000 || voice_release !== 4'b0000 || voice_active !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_no_strobe%0d: trig=%b rel=%b active=%b expected 0000/0000/0000",
                         c, voice_trigger, voice_release, voice_active);
            end
        end
        send_event(NOTE_ON, 7'd48, 7'd70, t, r);
        tests_run++;
        if (t !== 4'b0001 || r !== 4'b0000 || voice_note[0] !== 7'd48 || voice_active !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_then_alloc: trig=%b rel=%b note0=%0d active=%b expected 0001/0000/48/0001",
                     t, r, voice_note[0], voice_active);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_release();
        test_steal();
        test_back_to_back();
        test_retrigger();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Dispatcher stage that turns a stream of MIDI note events into per-voice note assignments for the synth voices. It keeps a voice table (active flag, note, velocity per voice) and resolves each event with two `Search` instances. One instance looks up the note among the active voices; the other finds the lowest-indexed free voice. It then allocates, retriggers, steals or releases a voice and drives one-cycle trigger/release strobes to the downstream voice generators.

## Interface
- `VOICE_COUNT`, 4: number of voices; power of two, ≥2.
- `NOTE_WIDTH`, 7: MIDI note number width.
- `VELOCITY_WIDTH`, 7: MIDI velocity width.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_l`  in  1  reset; asynchronous, active-low.
- `event_valid`  in  1  upstream has an event.
- `event_ready`  out  1  block can accept an event.
- `event_kind`  in  1  `dispatcher_pkg::event_kind_t`: `NOTE_OFF`=0, `NOTE_ON`=1.
- `event_note`  in  NOTE_WIDTH  note number.
- `event_velocity`  in  VELOCITY_WIDTH  velocity; ignored for `NOTE_OFF`.
- `voice_active`  out  VOICE_COUNT  bit i set = voice i is sounding.
- `voice_note`  out  [VOICE_COUNT] x NOTE_WIDTH  note per voice.
- `voice_velocity`  out  [VOICE_COUNT] x VELOCITY_WIDTH  velocity per voice.
- `voice_trigger`  out  VOICE_COUNT  one-cycle strobe: voice i (re)started.
- `voice_release`  out  VOICE_COUNT  one-cycle strobe: voice i released or stolen.

## Operation
- FSM states:
  - `IDLE`: `event_ready`=1. A transfer (`event_valid && event_ready` at a rising edge) latches kind, note and velocity, then goes to `LOOKUP`.
  - `LOOKUP`: registers both search results, then goes to `COMMIT`.
  - `COMMIT`: updates the table and strobes, then goes to `IDLE`.
- `event_ready` is combinational: `state == IDLE`.
- Note search:
  - needle `{1'b1, note}`; heystack element i `{voice_active[i], voice_note[i]}`; width NOTE_WIDTH+1.
  - Returns the lowest matching index, plus a hit flag.
- Free search: needle `1'b0`, heystack `voice_active`, width 1.
- `NOTE_ON` with velocity 0 is treated as `NOTE_OFF`.
- `NOTE_ON`, in priority order:
  - Note hit: retrigger that voice. Velocity is overwritten; trigger bit is set; release bit stays clear.
  - Else free voice found: write note and velocity to the free voice, set its active bit, set its trigger bit.
  - Else steal voice `steal_ptr`:
    - Overwrite its note and velocity.
    - Set both its release and trigger bits in the same cycle.
    - `steal_ptr` advances by 1, wrapping modulo VOICE_COUNT.
- `NOTE_OFF`:
  - Note hit: clear that voice's active bit and set its release bit. Note and velocity fields are retained.
  - Miss: no table change, no strobes.
- `steal_ptr` changes only on a steal.
- At most one voice changes per event.

## Timing
- Handshake at edge E0 → `LOOKUP` after E0 → `COMMIT` after E1.
- At E2:
  - Table outputs update.
  - Strobes go high for the cycle after E2.
  - FSM returns to `IDLE` (`event_ready`=1 in the same cycle).
- Next transfer is possible at E3. Throughput is one event per 3 cycles.
- Search results are sampled at E1 from the table as it stands. The table cannot change between E0 and E2.
- Strobes are registered and are zero in every cycle other than the one after a `COMMIT` edge.
- Reset (asynchronous) takes effect immediately, independent of `clock`:
  - FSM goes to `IDLE`.
  - `voice_active`, `voice_trigger` and `voice_release` go to 0.
  - `voice_note` and `voice_velocity` go to 0.
  - `steal_ptr` goes to 0.
  - `event_ready` goes to 1.
  - An event in flight is discarded with no strobe.
  - Transfers are ignored while `reset_l`=0.

## Structure
- `dispatcher_pkg` holds:
  - `event_kind_t`
  - `state_t` (`IDLE`, `LOOKUP`, `COMMIT`)
  - default `NOTE_WIDTH` and `VELOCITY_WIDTH` constants
- Two instances of the existing `Search` sub-module (note search and free search). No other sub-modules.
- Index width is `$clog2(VOICE_COUNT)`.

## Test plan
All scenarios use VOICE_COUNT=4.

- Reset → `voice_active`=4'b0000, strobes 0, `event_ready`=1, all notes 0.
- `NOTE_ON` 60/100, then `NOTE_ON` 64/80 → voice 0 = 60/100, voice 1 = 64/80. `voice_trigger` is 4'b0001, then 4'b0010, each in the cycle after E2. `event_ready` is low for exactly 2 cycles per event.
- Release and miss:
  - `NOTE_OFF` 60 → `voice_release`=4'b0001, `voice_active`=4'b0010.
  - Then `NOTE_OFF` 70 → no strobes, table unchanged.
- Stealing:
  - Fill with 60, 62, 64, 65; then `NOTE_ON` 67/90 → voice 0 stolen: release=trigger=4'b0001 in the same cycle, `voice_note[0]`=67.
  - `NOTE_ON` 69 → voice 1 stolen.
- Retrigger and velocity 0:
  - 62 active on voice 1, `NOTE_ON` 62/20 → trigger 4'b0010, release 0, `voice_velocity[1]`=20.
  - Then `NOTE_ON` 62/0 → release 4'b0010.
- Reset asserted during `LOOKUP` → outputs clear immediately, no strobe follows. After release, the next `NOTE_ON` 48 lands on voice 0.
